// File: rtl/wdata_pkg.sv
// Shared constants for the macroblock write-data path: beat and word geometry,
// AXI burst length, macroblock counter widths and the packer FSM encoding.
package wdata_pkg;

  localparam int IN_W          = 128;
  localparam int OUT_W         = 1024;
  localparam int LANES         = OUT_W / IN_W;
  localparam int WORDS_PER_MB  = 7;
  localparam int AXI_BURST_LEN = WORDS_PER_MB;

  localparam int MB_DIM_W = 11;
  localparam int MB_CNT_W = 2 * MB_DIM_W;

  localparam int ST_W = 6;
  localparam logic [ST_W-1:0] S_IDLE  = 6'b000001;
  localparam logic [ST_W-1:0] S_INIT  = 6'b000010;
  localparam logic [ST_W-1:0] S_PACK  = 6'b000100;
  localparam logic [ST_W-1:0] S_PAD   = 6'b001000;
  localparam logic [ST_W-1:0] S_DRAIN = 6'b010000;
  localparam logic [ST_W-1:0] S_DONE  = 6'b100000;

  function automatic logic [MB_CNT_W-1:0] mb_total_of(input logic [MB_DIM_W-1:0] w,
                                                      input logic [MB_DIM_W-1:0] h);
    return MB_CNT_W'(w) * MB_CNT_W'(h);
  endfunction

endpackage

// File: rtl/lane_assembler.sv
// Collects IN_W beats into an IN_W*LANES word and hands the word to the
// output register, zero-filling unwritten lanes when a pad load is requested.
module lane_assembler #(
  parameter int IN_W  = 128,
  parameter int LANES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [IN_W-1:0]       wr_data,
  input  logic                  pad_req,
  input  logic                  out_free,
  output logic                  load,
  output logic [IN_W*LANES-1:0] load_data
);

  localparam int LANE_W = $clog2(LANES);

  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [IN_W*LANES-1:0] asm_q, asm_d;

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    load      = (wr_en && lane_q == LANE_W'(LANES - 1)) || (pad_req && out_free);
    lane_d    = lane_q;
    asm_d     = asm_q;
    load_data = '0;

    if (clear || load) begin
      lane_d = '0;
    end else if (wr_en) begin
      lane_d = lane_q + LANE_W'(1);
    end

    // Lanes below lane_q hold this word's beats; everything at or above it loads as zero.
    for (int i = 0; i < LANES; i++) begin
      if (wr_en && lane_q == LANE_W'(i)) begin
        asm_d[i*IN_W +: IN_W] = wr_data;
      end
      if (LANE_W'(i) < lane_q) begin
        load_data[i*IN_W +: IN_W] = asm_q[i*IN_W +: IN_W];
      end else if (wr_en && LANE_W'(i) == lane_q) begin
        load_data[i*IN_W +: IN_W] = wr_data;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
    end else begin
      lane_q <= lane_d;
    end
  end

  // NOTE: the assembly data register has no reset; lane_q alone decides which lanes are valid.
  always_ff @(posedge clk) begin
    asm_q <= asm_d;
  end

endmodule

// File: rtl/mb_wdata_packer.sv
// Packs 128-bit encoder beats into 1024-bit FIFO words, seven words per
// macroblock, padding short macroblocks and signalling frame completion.
module mb_wdata_packer #(
  parameter int IN_W         = wdata_pkg::IN_W,
  parameter int OUT_W        = wdata_pkg::OUT_W,
  parameter int WORDS_PER_MB = wdata_pkg::WORDS_PER_MB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_pulse,
  input  logic [31:0]      mb_w,
  input  logic [31:0]      mb_h,
  output logic             done_pulse,
  output logic             protocol_err,
  input  logic             enc_valid,
  input  logic [IN_W-1:0]  enc_data,
  input  logic             enc_last,
  output logic             enc_ready,
  input  logic             fifo_full,
  output logic [OUT_W-1:0] fifo_din,
  output logic             fifo_wr
);

  import wdata_pkg::MB_DIM_W, wdata_pkg::MB_CNT_W, wdata_pkg::ST_W, wdata_pkg::mb_total_of;
  import wdata_pkg::S_IDLE, wdata_pkg::S_INIT, wdata_pkg::S_PACK;
  import wdata_pkg::S_PAD, wdata_pkg::S_DRAIN, wdata_pkg::S_DONE;

  localparam int LANES  = OUT_W / IN_W;
  localparam int WORD_W = $clog2(WORDS_PER_MB);

  logic [ST_W-1:0]     state_q, state_d;
  logic [WORD_W-1:0]   word_cnt_q, word_cnt_d;
  logic [MB_CNT_W-1:0] mb_count_q, mb_count_d;
  logic [MB_CNT_W-1:0] mb_total_q, mb_total_d;
  logic [MB_CNT_W-1:0] mb_product;
  logic                out_valid_q, out_valid_d;
  logic [OUT_W-1:0]    out_q, out_d;
  logic                perr_q, perr_d;

  logic             accept, out_free, pad_req, asm_clear, asm_load;
  logic             word_last, mb_end, mb_last;
  logic [OUT_W-1:0] load_data;
  logic             unused_dims;

  assign unused_dims  = ^{mb_w[31:MB_DIM_W], mb_h[31:MB_DIM_W]};

  assign enc_ready    = (state_q == S_PACK) && !(out_valid_q && fifo_full);
  assign fifo_wr      = out_valid_q && !fifo_full;
  assign fifo_din     = out_q;
  assign done_pulse   = (state_q == S_DONE);
  assign protocol_err = perr_q;

  assign accept    = enc_valid && enc_ready;
  assign out_free  = !out_valid_q || fifo_wr;
  assign pad_req   = (state_q == S_PAD);
  assign asm_clear = (state_q == S_IDLE) && start_pulse;

  lane_assembler #(
    .IN_W  (IN_W),
    .LANES (LANES)
  ) u_lane_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (asm_clear),
    .wr_en     (accept),
    .wr_data   (enc_data),
    .pad_req   (pad_req),
    .out_free  (out_free),
    .load      (asm_load),
    .load_data (load_data)
  );

  always_comb begin
    word_last  = (word_cnt_q == WORD_W'(WORDS_PER_MB - 1));
    mb_end     = asm_load && word_last;
    mb_last    = (mb_count_q + MB_CNT_W'(1)) == mb_total_q;
    mb_product = mb_total_of(mb_w[MB_DIM_W-1:0], mb_h[MB_DIM_W-1:0]);

    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    mb_count_d  = mb_count_q;
    mb_total_d  = mb_total_q;
    perr_d      = perr_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;

    // A load in the same cycle as a FIFO write keeps out_valid set.
    if (asm_load) begin
      out_valid_d = 1'b1;
      out_d       = load_data;
      word_cnt_d  = word_last ? '0 : word_cnt_q + WORD_W'(1);
    end else if (fifo_wr) begin
      out_valid_d = 1'b0;
    end

    if (mb_end) begin
      mb_count_d = mb_count_q + MB_CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start_pulse) begin
          state_d    = S_INIT;
          word_cnt_d = '0;
          mb_count_d = '0;
          perr_d     = 1'b0;
        end
      end
      S_INIT: begin
        mb_total_d = mb_product;
        state_d    = (mb_product == '0) ? S_DONE : S_PACK;
      end
      S_PACK: begin
        if (mb_end) begin
          if (!enc_last) begin
            perr_d = 1'b1;
          end
          state_d = mb_last ? S_DRAIN : S_PACK;
        end else if (accept && enc_last) begin
          state_d = S_PAD;
        end
      end
      S_PAD: begin
        if (mb_end) begin
          state_d = mb_last ? S_DRAIN : S_PACK;
        end
      end
      S_DRAIN: begin
        if (!out_valid_d) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      word_cnt_q  <= '0;
      mb_count_q  <= '0;
      mb_total_q  <= '0;
      perr_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      mb_count_q  <= mb_count_d;
      mb_total_q  <= mb_total_d;
      perr_q      <= perr_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

endmodule
